// File: rtl/spi_dbg_master_ctrl.sv
// spi_dbg_master_ctrl: SPI master turning cmd/data requests into debug-port chip-select frames
module spi_dbg_master_ctrl #(
  parameter int CMD_W    = 8,
  parameter int DATA_W   = 8,
  parameter int DIV_FAST = 4,
  parameter int DIV_SLOW = 16,
  parameter int GAP_CYC  = 4,
  parameter bit CPOL     = 1'b0
) (
  input  logic              i_nano_clk,
  input  logic              i_nano_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [CMD_W-1:0]  i_req_cmd,
  input  logic [DATA_W-1:0] i_req_wdata,
  input  logic              i_req_is_read,
  input  logic              i_req_slow,
  input  logic              i_abort,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_done,
  output logic              o_busy,
  input  logic              i_dbg_spi_miso,
  output logic              o_dbg_spi_en_n,
  output logic              o_dbg_spi_mosi,
  output logic              o_dbg_spi_sclk
);
  localparam int N    = CMD_W + DATA_W;
  localparam int MAXD = DIV_SLOW > DIV_FAST ? DIV_SLOW : DIV_FAST;
  localparam int MAXC = MAXD > GAP_CYC ? MAXD : GAP_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int BW   = $clog2(N + 1);
  // GAP exits one cycle early so ready is already high on the edge that ends the chip-enable gap
  localparam int GL   = GAP_CYC > 1 ? GAP_CYC - 2 : 0;

  typedef enum logic [2:0] {IDLE, SETUP, ACTIVE, HOLD, GAP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, div_q, div_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [N-1:0]      tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d, rsp_data_q, rsp_data_d;
  logic              is_read_q, is_read_d, en_n_q, en_n_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic              ready_q, ready_d, busy_q, busy_d, done_q, done_d, rsp_valid_q, rsp_valid_d;
  logic              tick, last;

  assign tick = cnt_q == div_q;
  assign last = bit_q == BW'(N - 1);

  assign o_req_ready    = ready_q;
  assign o_rsp_valid    = rsp_valid_q;
  assign o_rsp_data     = rsp_data_q;
  assign o_done         = done_q;
  assign o_busy         = busy_q;
  assign o_dbg_spi_en_n = en_n_q;
  assign o_dbg_spi_mosi = mosi_q;
  assign o_dbg_spi_sclk = sclk_q;

  // Frame sequencer: phase counting, bit shifting, response and abort handling
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    div_d       = div_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rsp_data_d  = rsp_data_q;
    is_read_d   = is_read_q;
    en_n_d      = en_n_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rsp_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        cnt_d   = '0;
        if (i_req_valid && ready_q) begin
          state_d   = SETUP;
          div_d     = i_req_slow ? CW'(DIV_SLOW - 1) : CW'(DIV_FAST - 1);
          tx_d      = {i_req_cmd, i_req_is_read ? {DATA_W{1'b0}} : i_req_wdata} << 1;
          is_read_d = i_req_is_read;
          mosi_d    = i_req_cmd[CMD_W-1];
          bit_d     = '0;
          rx_d      = '0;
          en_n_d    = 1'b0;
          busy_d    = 1'b1;
          ready_d   = 1'b0;
        end
      end
      SETUP: if (tick) begin
        cnt_d   = '0;
        sclk_d  = !CPOL;
        state_d = ACTIVE;
      end
      ACTIVE: if (tick) begin
        cnt_d   = '0;
        sclk_d  = CPOL;
        rx_d    = DATA_W'({rx_q, i_dbg_spi_miso});
        state_d = HOLD;
      end
      HOLD: if (tick) begin
        cnt_d       = '0;
        state_d     = last ? (GAP_CYC > 1 ? GAP : IDLE) : SETUP;
        bit_d       = last ? bit_q : bit_q + BW'(1);
        mosi_d      = last ? 1'b0 : tx_q[N-1];
        tx_d        = tx_q << 1;
        en_n_d      = last;
        done_d      = last;
        rsp_valid_d = last && is_read_q;
        rsp_data_d  = last && is_read_q ? rx_q : rsp_data_q;
        ready_d     = last && GAP_CYC == 1;
        busy_d      = !(last && GAP_CYC == 1);
      end
      GAP: if (cnt_q == CW'(GL)) begin
        cnt_d   = '0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (i_abort && (state_q == SETUP || state_q == ACTIVE || state_q == HOLD)) begin
      state_d     = GAP_CYC > 1 ? GAP : IDLE;
      cnt_d       = '0;
      en_n_d      = 1'b1;
      sclk_d      = CPOL;
      mosi_d      = 1'b0;
      done_d      = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      ready_d     = GAP_CYC == 1;
      busy_d      = GAP_CYC > 1;
    end
  end

  // State and output registers, cleared asynchronously to the idle bus levels
  always_ff @(posedge i_nano_clk or negedge i_nano_rst_n) begin
    if (!i_nano_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rsp_data_q  <= '0;
      is_read_q   <= 1'b0;
      en_n_q      <= 1'b1;
      sclk_q      <= CPOL;
      mosi_q      <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rsp_data_q  <= rsp_data_d;
      is_read_q   <= is_read_d;
      en_n_q      <= en_n_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end
endmodule

// File: tb/tb_spi_dbg_master_ctrl.sv
// tb_spi_dbg_master_ctrl: scoreboard bench for the debug SPI master (default and CPOL=1 wide-data builds)
module tb_spi_dbg_master_ctrl;
  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0, sclk_err = 0;

  logic        v1 = 0, rdy1, rd1 = 0, sl1 = 0, ab1 = 0, rv1, done1, busy1, miso1 = 0, en1, mosi1, sclk1;
  logic [7:0]  cmd1 = 0, wd1 = 0, rsp1;
  logic        v2 = 0, rdy2, rd2 = 1, sl2 = 0, ab2 = 0, rv2, done2, busy2, miso2 = 0, en2, mosi2, sclk2;
  logic [3:0]  cmd2 = 0;
  logic [15:0] wd2 = 0, rsp2;

  spi_dbg_master_ctrl dut1 (
    .i_nano_clk(clk), .i_nano_rst_n(rst_n), .i_req_valid(v1), .o_req_ready(rdy1),
    .i_req_cmd(cmd1), .i_req_wdata(wd1), .i_req_is_read(rd1), .i_req_slow(sl1), .i_abort(ab1),
    .o_rsp_valid(rv1), .o_rsp_data(rsp1), .o_done(done1), .o_busy(busy1),
    .i_dbg_spi_miso(miso1), .o_dbg_spi_en_n(en1), .o_dbg_spi_mosi(mosi1), .o_dbg_spi_sclk(sclk1)
  );

  spi_dbg_master_ctrl #(.CMD_W(4), .DATA_W(16), .DIV_FAST(1), .CPOL(1'b1)) dut2 (
    .i_nano_clk(clk), .i_nano_rst_n(rst_n), .i_req_valid(v2), .o_req_ready(rdy2),
    .i_req_cmd(cmd2), .i_req_wdata(wd2), .i_req_is_read(rd2), .i_req_slow(sl2), .i_abort(ab2),
    .o_rsp_valid(rv2), .o_rsp_data(rsp2), .o_done(done2), .o_busy(busy2),
    .i_dbg_spi_miso(miso2), .o_dbg_spi_en_n(en2), .o_dbg_spi_mosi(mosi2), .o_dbg_spi_sclk(sclk2)
  );

  typedef struct {
    int          t;
    logic        rd;
    logic [31:0] mosi;
    logic [31:0] data;
  } exp_t;
  exp_t q1[$], q2[$];
  exp_t e1, e2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // SPI slave models: capture MOSI and present MISO on the leading SCLK edge
  logic [7:0]  mdat1 = 0;
  logic [15:0] mdat2 = 0;
  logic [31:0] mcap1 = 0, mcap2 = 0;
  int k1 = 0, k2 = 0;
  always @(negedge en1) begin k1 = 0; mcap1 = 0; end
  always @(negedge en2) begin k2 = 0; mcap2 = 0; end
  always @(posedge sclk1) if (!en1) begin
    mcap1 = {mcap1[30:0], mosi1};
    miso1 = (k1 >= 8 && k1 < 16) ? mdat1[15-k1] : 1'b1;
    k1++;
  end
  always @(negedge sclk2) if (!en2) begin
    mcap2 = {mcap2[30:0], mosi2};
    miso2 = (k2 >= 4 && k2 < 20) ? mdat2[19-k2] : 1'b1;
    k2++;
  end

  // Monitor: pops the scoreboard whenever a frame ends or a response appears
  always @(negedge clk) begin
    if (en1 && sclk1 !== 1'b0) sclk_err++;
    if (en2 && sclk2 !== 1'b1) sclk_err++;
    if (done1 || rv1) begin
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL dut1_unexpected_rsp: done=%b rsp_valid=%b, expected none (cycle %0d)", done1, rv1, cyc);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_end_cycle", cyc, e1.t);
        chk("dut1_done", done1, 1);
        chk("dut1_rsp_valid", rv1, e1.rd);
        if (e1.rd) chk("dut1_rsp_data", rsp1, e1.data);
        chk("dut1_mosi_bits", mcap1[15:0], e1.mosi);
        chk("dut1_en_n_end", en1, 1);
      end
    end
    if (done2 || rv2) begin
      if (q2.size() == 0) begin
        tests++; fails++;
        $display("FAIL dut2_unexpected_rsp: done=%b rsp_valid=%b, expected none (cycle %0d)", done2, rv2, cyc);
      end else begin
        e2 = q2.pop_front();
        chk("dut2_end_cycle", cyc, e2.t);
        chk("dut2_done", done2, 1);
        chk("dut2_rsp_valid", rv2, e2.rd);
        if (e2.rd) chk("dut2_rsp_data", rsp2, e2.data);
        chk("dut2_mosi_bits", mcap2[19:0], e2.mosi);
      end
    end
  end

  task automatic issue1(input logic [7:0] c, input logic [7:0] w, input logic r, input logic s,
                        input logic [7:0] md, input bit push, input bit hold, output int e0);
    int d;
    cmd1 = c; wd1 = w; rd1 = r; sl1 = s; mdat1 = md; v1 = 1;
    for (int i = 0; i < 1000 && !rdy1; i++) @(negedge clk);
    if (!rdy1) begin
      tests++; fails++;
      $display("FAIL issue1_timeout: ready=%b, expected 1", rdy1);
      v1 = 0; e0 = -1;
      return;
    end
    e0 = cyc + 1;
    d = s ? 16 : 4;
    if (push) q1.push_back('{e0 + 3 * d * 16, r, {16'h0, c, r ? 8'h00 : w}, {24'h0, md}});
    @(negedge clk);
    if (!hold) v1 = 0;
    chk("accept_en_n", en1, 0);
    chk("accept_busy", busy1, 1);
    chk("accept_ready", rdy1, 0);
    chk("accept_mosi_msb", mosi1, c[7]);
  endtask

  task automatic drain();
    for (int i = 0; i < 4000 && (q1.size() != 0 || q2.size() != 0); i++) @(negedge clk);
    if (q1.size() != 0 || q2.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: pending dut1=%0d dut2=%0d, expected 0", q1.size(), q2.size());
      q1.delete(); q2.delete();
    end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int e0, ea, eb, ec, a;
    #1 rst_n = 0;
    #20;
    chk("rst_en_n", en1, 1);
    chk("rst_sclk", sclk1, 0);
    chk("rst_mosi", mosi1, 0);
    chk("rst_ready", rdy1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_rsp_valid", rv1, 0);
    chk("rst_done", done1, 0);
    chk("rst_rsp_data", rsp1, 0);
    chk("rst_sclk_cpol1", sclk2, 1);
    @(negedge clk) rst_n = 1;
    repeat (2) @(negedge clk);
    chk("ready_after_rst", rdy1, 1);

    issue1(8'h60, 8'hA5, 0, 0, 8'h00, 1, 0, e0);
    drain();

    issue1(8'h90, 8'h00, 1, 1, 8'h3C, 1, 0, e0);
    drain();

    issue1(8'h11, 8'h22, 0, 0, 8'h00, 1, 1, ea);
    issue1(8'h33, 8'h44, 0, 0, 8'h00, 1, 1, eb);
    issue1(8'h55, 8'h66, 0, 0, 8'h00, 1, 0, ec);
    chk("b2b_spacing_1", eb - ea, 196);
    chk("b2b_spacing_2", ec - eb, 196);
    drain();

    issue1(8'h91, 8'h00, 1, 0, 8'h77, 0, 0, e0);
    while (cyc < e0 + 62) @(negedge clk);
    ab1 = 1;
    @(negedge clk);
    ab1 = 0;
    a = cyc;
    chk("abort_en_n", en1, 1);
    chk("abort_sclk", sclk1, 0);
    chk("abort_mosi", mosi1, 0);
    chk("abort_rsp_data_kept", rsp1, 8'h3C);
    while (cyc < a + 2) @(negedge clk);
    chk("abort_ready_still_low", rdy1, 0);
    @(negedge clk);
    chk("abort_ready_back", rdy1, 1);
    chk("abort_busy_cleared", busy1, 0);
    while (cyc < e0 + 200) @(negedge clk);

    issue1(8'h55, 8'h0F, 0, 0, 8'h00, 0, 0, e0);
    while (cyc < e0 + 5) @(negedge clk);
    chk("pre_rst_sclk_high", sclk1, 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_en_n", en1, 1);
    chk("async_rst_sclk", sclk1, 0);
    chk("async_rst_mosi", mosi1, 0);
    chk("async_rst_busy", busy1, 0);
    chk("async_rst_ready", rdy1, 0);
    @(negedge clk) rst_n = 1;
    repeat (2) @(negedge clk);
    issue1(8'hC3, 8'h5A, 0, 0, 8'h00, 1, 0, e0);
    drain();

    chk("cpol1_idle_sclk", sclk2, 1);
    cmd2 = 4'hA; rd2 = 1; mdat2 = 16'hBEEF; v2 = 1;
    for (int i = 0; i < 100 && !rdy2; i++) @(negedge clk);
    if (!rdy2) begin
      tests++; fails++;
      $display("FAIL issue2_timeout: ready=%b, expected 1", rdy2);
    end else begin
      q2.push_back('{cyc + 1 + 60, 1'b1, {12'h0, 4'hA, 16'h0000}, {16'h0, 16'hBEEF}});
    end
    @(negedge clk);
    v2 = 0;
    drain();

    chk("sclk_idle_while_en_n_high", sclk_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
